// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target address, R/W encoding and master FSM states.
package i2c_pkg;

    localparam logic [6:0]  I2C_SLAVE_ADDR = 7'd52;
    localparam logic        I2C_WR         = 1'b0;
    localparam int unsigned I2C_DATA_W     = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP
    } mst_state_t;

endpackage

// File: rtl/i2c_master_tx_if.sv
// Request/response handshake between a requester and the I2C transmit master.
interface i2c_master_tx_if;

    logic                            start;
    logic [i2c_pkg::I2C_DATA_W-1:0] tx_data;
    logic                            busy;
    logic                            done;
    logic                            nack;

    modport master (
        input  start,
        input  tx_data,
        output busy,
        output done,
        output nack
    );

    modport slave (
        output start,
        output tx_data,
        input  busy,
        input  done,
        input  nack
    );

endinterface

// File: rtl/i2c_quarter_tick.sv
// Divides clk into one-cycle ticks, one per SCL quarter-period.
module i2c_quarter_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned     CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running divider while enabled; held at zero otherwise.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples pre-edge values, independent of block ordering.
        if (rst || clr || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_master_tx.sv
// Transmit-only I2C master: START, address+W, two data bytes, STOP.
module i2c_master_tx
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [6:0]  SLAVE_ADDR = I2C_SLAVE_ADDR
) (
    input  logic             clk,
    input  logic             rst,
    i2c_master_tx_if.master  bus,
    output logic             scl,
    inout  wire              sda
);

    mst_state_t  state, state_nx;
    logic [1:0]  q, q_nx;
    logic [2:0]  bit_cnt, bit_nx;
    logic [1:0]  byte_idx, byte_nx;
    logic [23:0] shreg, shreg_nx;
    logic        ack_bit, ack_nx;
    logic        nack_r, nack_nx;
    logic        done_r, done_nx;
    logic        sda_meta, sda_sync;
    logic        sda_low;
    logic        tick;
    logic        accept;

    // A start arriving in the done cycle is deliberately dropped.
    assign accept = (state == ST_IDLE) && bus.start && !done_r;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state != ST_IDLE),
        .clr  (accept),
        .tick (tick)
    );

    // Two-flop synchronizer on the open-drain SDA line.
    always_ff @(posedge clk) begin
        if (rst) begin
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            sda_meta <= sda;
            sda_sync <= sda_meta;
        end
    end

    // Register FSM state and all datapath state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            q        <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            ack_bit  <= 1'b1;
            nack_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_nx;
            q        <= q_nx;
            bit_cnt  <= bit_nx;
            byte_idx <= byte_nx;
            shreg    <= shreg_nx;
            ack_bit  <= ack_nx;
            nack_r   <= nack_nx;
            done_r   <= done_nx;
        end
    end

    // Next-state, quarter sequencing and bus pin decode.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nx = state;
        q_nx     = q;
        bit_nx   = bit_cnt;
        byte_nx  = byte_idx;
        shreg_nx = shreg;
        ack_nx   = ack_bit;
        nack_nx  = nack_r;
        done_nx  = 1'b0;
        scl      = 1'b1;
        sda_low  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_START;
                    shreg_nx = {SLAVE_ADDR, I2C_WR, bus.tx_data, 4'b0000};
                    nack_nx  = 1'b0;
                    byte_nx  = '0;
                    bit_nx   = '0;
                    q_nx     = '0;
                end
            end
            ST_START: begin
                sda_low = (q == 2'd1);
                if (tick) begin
                    if (q == 2'd1) begin
                        state_nx = ST_BIT;
                        q_nx     = '0;
                        bit_nx   = '0;
                    end else begin
                        q_nx = q + 2'd1;
                    end
                end
            end
            ST_BIT: begin
                scl     = (q == 2'd1) || (q == 2'd2);
                sda_low = !shreg[23];
                if (tick) begin
                    q_nx = q + 2'd1;
                    if (q == 2'd3) begin
                        shreg_nx = {shreg[22:0], 1'b0};
                        bit_nx   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_nx = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                scl = (q == 2'd1) || (q == 2'd2);
                if (tick) begin
                    q_nx = q + 2'd1;
                    if (q == 2'd1) ack_nx = sda_sync;
                    if (q == 2'd3) begin
                        if (ack_bit) begin
                            nack_nx  = 1'b1;
                            state_nx = ST_STOP;
                        end else if (byte_idx < 2'd2) begin
                            byte_nx  = byte_idx + 2'd1;
                            state_nx = ST_BIT;
                        end else begin
                            state_nx = ST_STOP;
                        end
                    end
                end
            end
            ST_STOP: begin
                scl     = (q != 2'd0);
                sda_low = (q != 2'd2);
                if (tick) begin
                    if (q == 2'd2) begin
                        state_nx = ST_IDLE;
                        q_nx     = '0;
                        done_nx  = 1'b1;
                    end else begin
                        q_nx = q + 2'd1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign sda      = sda_low ? 1'b0 : 1'bz;
    assign bus.busy = (state != ST_IDLE) || done_r;
    assign bus.done = done_r;
    assign bus.nack = nack_r;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Scoreboard bench for i2c_master_tx with a behavioural I2C slave receiver.
module tb_i2c_master_tx;

    localparam int CLK_DIV = 4;

    typedef struct {
        logic [15:0] word;
        logic        nack;
        int          lat;
        int          rises;
        int          acc;
    } exp_t;

    logic clk;
    logic rst;
    logic scl;
    wire  sda;
    logic slave_low;

    i2c_master_tx_if bus_if ();

    i2c_master_tx #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(7'd52)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if),
        .scl (scl),
        .sda (sda)
    );

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    int   n_push   = 0;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural slave receiver ----------------
    logic [6:0]  slave_addr = 7'd52;
    int          nack_at    = -1;
    logic [15:0] rx_word    = '0;
    int          last_rises = 0;
    int          last_gap   = 0;
    logic        p_scl = 1'b1, p_sda = 1'b1, c_scl, c_sda;
    logic        s_active = 1'b0, s_in_ack = 1'b0, s_addr_ok = 1'b0;
    logic [7:0]  s_sh = '0, s_b1 = '0, s_b2 = '0;
    int          s_bits = 0, s_bytes = 0, s_rises = 0, s_stop_cyc = 0;

    initial begin : slave_model
        slave_low = 1'b0;
        forever begin
            @(negedge clk);
            c_scl = scl;
            c_sda = sda;
            if (rst) begin
                s_active  = 1'b0;
                s_in_ack  = 1'b0;
                slave_low = 1'b0;
            end else if (p_scl && c_scl && p_sda && !c_sda) begin
                s_active = 1'b1;
                s_in_ack = 1'b0;
                s_bits   = 0;
                s_bytes  = 0;
                s_rises  = 0;
                last_gap = cyc - s_stop_cyc;
            end else if (p_scl && c_scl && !p_sda && c_sda) begin
                if (s_active) begin
                    last_rises = s_rises;
                    rx_word    = {s_b1, s_b2};
                end
                s_active   = 1'b0;
                s_stop_cyc = cyc;
            end else if (s_active && !p_scl && c_scl) begin
                s_rises++;
                if (s_bits < 8) begin
                    s_sh = {s_sh[6:0], c_sda};
                    s_bits++;
                end
            end else if (s_active && p_scl && !c_scl) begin
                if (s_in_ack) begin
                    s_in_ack  = 1'b0;
                    slave_low = 1'b0;
                    s_bits    = 0;
                    s_bytes++;
                end else if (s_bits == 8) begin
                    s_in_ack = 1'b1;
                    if (s_bytes == 0) begin
                        s_addr_ok = (s_sh == {slave_addr, 1'b0});
                        slave_low = s_addr_ok;
                    end else begin
                        if (s_bytes == 1) s_b1 = s_sh;
                        if (s_bytes == 2) s_b2 = s_sh;
                        slave_low = s_addr_ok && (s_bytes != nack_at);
                    end
                end
            end
            p_scl = c_scl;
            p_sda = c_sda;
        end
    end

    // ---------------- monitor: pop and compare on every done ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_if.done === 1'b1) begin
                n_done++;
                check("done_expected", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("latency", cyc - e.acc, e.lat);
                    check("nack", bus_if.nack, e.nack);
                    check("busy_at_done", bus_if.busy, 1'b1);
                    check("scl_rises", last_rises, e.rises);
                    if (!e.nack) check("rx_word", rx_word, e.word);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int acc_cyc;

    task automatic issue(input logic [11:0] d, input bit push, input logic exp_nack,
                         input int lat, input int rises);
        @(negedge clk);
        bus_if.start   = 1'b1;
        bus_if.tx_data = d;
        @(negedge clk);
        bus_if.start = 1'b0;
        acc_cyc      = cyc;
        if (push) begin
            sb_q.push_back('{word: {d, 4'h0}, nack: exp_nack, lat: lat, rises: rises, acc: acc_cyc});
            n_push++;
        end
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.done !== 1'b1 && n < limit);
        check("done_seen", bus_if.done, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stimulus
        rst            = 1'b1;
        bus_if.start   = 1'b0;
        bus_if.tx_data = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {scl, sda, bus_if.busy, bus_if.done, bus_if.nack}, 5'b11000);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_bus", {scl, sda, bus_if.busy, bus_if.done}, 4'b1100);
        end

        // Normal transfer: 113 quarters, 27 bit/ACK clocks + STOP clock.
        issue(12'hA5C, 1'b1, 1'b0, 113 * CLK_DIV, 28);
        check("busy_after_accept", bus_if.busy, 1'b1);
        wait_done(2000);

        // Address NACK: 41 quarters, only the address byte is clocked.
        slave_addr = 7'd53;
        issue(12'hA5C, 1'b1, 1'b1, 41 * CLK_DIV, 10);
        wait_done(2000);
        repeat (5) @(negedge clk);
        check("nack_holds", bus_if.nack, 1'b1);
        slave_addr = 7'd52;

        // start while busy with different data is ignored.
        issue(12'h3C7, 1'b1, 1'b0, 113 * CLK_DIV, 28);
        check("nack_cleared_on_accept", bus_if.nack, 1'b0);
        repeat (50) @(negedge clk);
        bus_if.start   = 1'b1;
        bus_if.tx_data = 12'h123;
        @(negedge clk);
        bus_if.start = 1'b0;
        check("busy_during_ignored_start", bus_if.busy, 1'b1);
        wait_done(2000);

        // Data byte 1 NACK: 77 quarters, second data byte never sent.
        nack_at = 1;
        issue(12'h5A5, 1'b1, 1'b1, 77 * CLK_DIV, 19);
        wait_done(2000);
        nack_at = -1;

        // Reset mid-transfer aborts silently; next word completes.
        issue(12'h7E1, 1'b0, 1'b0, 0, 0);
        while (cyc - acc_cyc < 199) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_transfer", {scl, sda, bus_if.busy, bus_if.done, bus_if.nack}, 5'b11000);
        rst = 1'b0;
        issue(12'h001, 1'b1, 1'b0, 113 * CLK_DIV, 28);
        wait_done(2000);

        // Back-to-back: start held from the done cycle; accepted one cycle later.
        bus_if.start   = 1'b1;
        bus_if.tx_data = 12'hFFF;
        @(negedge clk);
        check("start_in_done_cycle_ignored", bus_if.busy, 1'b0);
        @(negedge clk);
        bus_if.start = 1'b0;
        acc_cyc      = cyc;
        sb_q.push_back('{word: 16'hFFF0, nack: 1'b0, lat: 113 * CLK_DIV, rises: 28, acc: acc_cyc});
        n_push++;
        check("b2b_accepted", bus_if.busy, 1'b1);
        wait_done(2000);
        check("stop_to_start_gap", last_gap >= CLK_DIV, 1'b1);

        repeat (10) @(negedge clk);
        check("done_count", n_done, n_push);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
